// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the scrolling 7-segment word feeder.
// Glyphs are active-low abcdefgh: bit7=a ... bit1=g, bit0=h (dp).
package seg_pkg;

  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL
`ifdef SEG_SCROLL_PAUSE_EN
    ,
    ST_PAUSE
`endif
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_E     = 8'h61;
  localparam logic [7:0] SEG_R     = 8'hF5;
  localparam logic [7:0] SEG_O     = 8'h03;
  localparam logic [7:0] SEG_P     = 8'h31;
  localparam logic [7:0] SEG_C     = 8'h63;
  localparam logic [7:0] SEG_H     = 8'hD1;
  localparam logic [7:0] SEG_I     = 8'hF3;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= "a" && c <= "z")
      return c - 8'd32;
    return c;
  endfunction

endpackage

// File: rtl/ascii_to_seg.sv
// Combinational ASCII to active-low abcdefgh glyph decoder.
// Letters are case-insensitive; unsupported characters render blank.
module ascii_to_seg
  import seg_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] seg
);

  logic [7:0] up;

  always_comb begin
    up  = to_upper(ascii);
    seg = SEG_BLANK;
    case (up)
      "0": seg = SEG_0;
      "1": seg = 8'h9F;
      "2": seg = 8'h25;
      "3": seg = 8'h0D;
      "4": seg = 8'h99;
      "5": seg = 8'h49;
      "6": seg = 8'h41;
      "7": seg = 8'h1F;
      "8": seg = 8'h01;
      "9": seg = 8'h09;
      "A": seg = 8'h11;
      "B": seg = 8'hC1;
      "C": seg = SEG_C;
      "D": seg = 8'h85;
      "E": seg = SEG_E;
      "F": seg = 8'h71;
      "G": seg = 8'h43;
      "H": seg = SEG_H;
      "I": seg = SEG_I;
      "J": seg = 8'h87;
      "K": seg = 8'h51;
      "L": seg = 8'hE3;
      "M": seg = 8'h57;
      "N": seg = 8'hD5;
      "O": seg = SEG_O;
      "P": seg = SEG_P;
      "Q": seg = 8'h19;
      "R": seg = SEG_R;
      "S": seg = 8'h49;
      "T": seg = 8'hE1;
      "U": seg = 8'h83;
      "V": seg = 8'hC7;
      "W": seg = 8'hA9;
      "X": seg = 8'h91;
      "Y": seg = 8'h89;
      "Z": seg = 8'h25;
      "-": seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_word_scroller.sv
// Marquee scroller: 4-character window over a writable ASCII buffer.
// Define SEG_SCROLL_PAUSE_EN to hold position 0 for PAUSE_TICKS steps after wrap.
module seg_word_scroller
  import seg_pkg::*;
#(
  parameter int MSG_LEN_MAX = 16,
  parameter int TICK_DIV    = 12_500_000,
  parameter int PAUSE_TICKS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN_MAX)-1:0] wr_addr,
  input  logic [7:0]                   wr_char,
  input  logic                         start,
  input  logic                         stop,
  input  logic [$clog2(MSG_LEN_MAX):0] cfg_len,
  output logic [31:0]                  word_seg,
  output logic                         seg_valid,
  output logic                         busy,
  output logic                         wrap
);

  localparam int AW = $clog2(MSG_LEN_MAX);
  localparam int LW = AW + 1;
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
`ifdef SEG_SCROLL_PAUSE_EN
  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_TICKS * TICK_DIV - 1);
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   pos_q, pos_d;
  logic [31:0]     tick_q, tick_d;
  logic [LW-1:0]   len_q, len_d;
  logic            wrap_d;
  logic            len_ok;
  logic            last;
  logic [7:0]      buf_q [MSG_LEN_MAX];
  logic [7:0]      char_w [DIGITS];
  logic [7:0]      glyph_w [DIGITS];

  // Reduce pos+k modulo len; enough passes for len down to 1.
  function automatic logic [AW-1:0] win_idx(
    input logic [AW-1:0] p,
    input int            k,
    input logic [LW-1:0] l
  );
    logic [LW:0] i;
    i = (LW+1)'(p) + (LW+1)'(k);
    for (int n = 0; n < DIGITS; n++)
      if (l != '0 && i >= {1'b0, l})
        i = i - {1'b0, l};
    return i[AW-1:0];
  endfunction

  assign len_ok = (cfg_len != '0) && (cfg_len <= LW'(MSG_LEN_MAX));
  assign last   = ({1'b0, pos_q} == len_q - 1'b1);
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (wr_en)
      buf_q[wr_addr] <= wr_char;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign char_w[k] = buf_q[win_idx(pos_q, k, len_q)];
    ascii_to_seg u_dec (
      .ascii (char_w[k]),
      .seg   (glyph_w[k])
    );
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tick_d  = tick_q;
    len_d   = len_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_SCROLL: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (last) begin
            pos_d  = '0;
            wrap_d = 1'b1;
`ifdef SEG_SCROLL_PAUSE_EN
            state_d = ST_PAUSE;
`endif
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
`ifdef SEG_SCROLL_PAUSE_EN
      ST_PAUSE: begin
        if (tick_q == PAUSE_LAST) begin
          tick_d  = '0;
          state_d = ST_SCROLL;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (start && len_ok) begin
      state_d = ST_SCROLL;
      pos_d   = '0;
      tick_d  = '0;
      len_d   = cfg_len;
      wrap_d  = 1'b0;
    end
    if (stop) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      tick_d  = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      tick_q    <= '0;
      len_q     <= '0;
      wrap      <= 1'b0;
      word_seg  <= '1;
      seg_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      wrap    <= wrap_d;
      if (stop || state_q == ST_IDLE) begin
        word_seg  <= '1;
        seg_valid <= 1'b0;
      end else begin
        word_seg  <= {glyph_w[0], glyph_w[1], glyph_w[2], glyph_w[3]};
        seg_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_word_scroller.sv
// Directed bench for seg_word_scroller with TICK_DIV=4, MSG_LEN_MAX=16.
// Builds with or without SEG_SCROLL_PAUSE_EN (PAUSE_TICKS=2 when enabled).
module tb_seg_word_scroller;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_char;
  logic        start;
  logic        stop;
  logic [4:0]  cfg_len;
  logic [31:0] word_seg;
  logic        seg_valid;
  logic        busy;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_word_scroller #(
    .MSG_LEN_MAX (16),
    .TICK_DIV    (4)
`ifdef SEG_SCROLL_PAUSE_EN
    ,
    .PAUSE_TICKS (2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .start     (start),
    .stop      (stop),
    .cfg_len   (cfg_len),
    .word_seg  (word_seg),
    .seg_valid (seg_valid),
    .busy      (busy),
    .wrap      (wrap)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] c);
    wr_en = 1'b1;
    wr_addr = a;
    wr_char = c;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] l);
    start = 1'b1;
    cfg_len = l;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(3);
    checks++;
    if (word_seg !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rst_word got %h want FFFFFFFF", word_seg);
    end
    checks++;
    if (seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", seg_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_wrap got %b want 0", wrap);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_scroll;
    wr(4'd0, "E");
    wr(4'd1, "r");
    wr(4'd2, "O");
    wr(4'd3, "P");
    go(5'd4);
    checks++;
    if (busy !== 1'b1 || seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_c1 got busy=%b valid=%b want 1 0", busy, seg_valid);
    end
    step(1);
    checks++;
    if (word_seg !== 32'h61F5_0331) begin
      errors++;
      $display("FAIL win_pos0 got %h want 61F50331", word_seg);
    end
    checks++;
    if (seg_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_on got %b want 1", seg_valid);
    end
    step(4);
    checks++;
    if (word_seg !== 32'hF503_3161) begin
      errors++;
      $display("FAIL win_pos1 got %h want F5033161", word_seg);
    end
  endtask

  task automatic test_wrap;
    int wcnt;
    int wat;
    wcnt = 0;
    wat = 0;
    go(5'd4);
    for (int n = 2; n <= 30; n++) begin
      step(1);
      if (wrap === 1'b1) begin
        wcnt++;
        wat = n;
      end
      if (n == 17) begin
        checks++;
        if (word_seg !== 32'h3161_F503) begin
          errors++;
          $display("FAIL win_pos3 got %h want 3161F503", word_seg);
        end
      end
      if (n == 18) begin
        checks++;
        if (word_seg !== 32'h61F5_0331) begin
          errors++;
          $display("FAIL wrap_win got %h want 61F50331", word_seg);
        end
      end
`ifdef SEG_SCROLL_PAUSE_EN
      if (n == 29) begin
        checks++;
        if (word_seg !== 32'h61F5_0331) begin
          errors++;
          $display("FAIL pause_hold got %h want 61F50331", word_seg);
        end
      end
      if (n == 30) begin
        checks++;
        if (word_seg !== 32'hF503_3161) begin
          errors++;
          $display("FAIL pause_adv got %h want F5033161", word_seg);
        end
      end
`else
      if (n == 22) begin
        checks++;
        if (word_seg !== 32'hF503_3161) begin
          errors++;
          $display("FAIL wrap_adv got %h want F5033161", word_seg);
        end
      end
`endif
    end
    checks++;
    if (wcnt != 1 || wat != 17) begin
      errors++;
      $display("FAIL wrap_pulse got cnt=%0d at=%0d want 1 17", wcnt, wat);
    end
  endtask

  task automatic test_short_len;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wr(4'd0, "H");
    wr(4'd1, "i");
    go(5'd2);
    step(1);
    checks++;
    if (word_seg !== 32'hD1F3_D1F3) begin
      errors++;
      $display("FAIL len2_pos0 got %h want D1F3D1F3", word_seg);
    end
    step(4);
    checks++;
    if (word_seg !== 32'hF3D1_F3D1) begin
      errors++;
      $display("FAIL len2_pos1 got %h want F3D1F3D1", word_seg);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || seg_valid !== 1'b0 || word_seg !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stop got busy=%b valid=%b word=%h want 0 0 FFFFFFFF",
               busy, seg_valid, word_seg);
    end
    go(5'd0);
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_ignored got busy=%b want 0", busy);
    end
    go(5'd17);
    step(1);
    checks++;
    if (busy !== 1'b0 || seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL len17_ignored got busy=%b valid=%b want 0 0", busy, seg_valid);
    end
  endtask

  task automatic test_live_write;
    wr(4'd0, "0");
    wr(4'd1, "1");
    wr(4'd2, "2");
    wr(4'd3, "3");
    go(5'd4);
    step(1);
    checks++;
    if (word_seg !== 32'h039F_250D) begin
      errors++;
      $display("FAIL digits got %h want 039F250D", word_seg);
    end
    wr(4'd0, "C");
    checks++;
    if (word_seg !== 32'h039F_250D) begin
      errors++;
      $display("FAIL same_cycle_old got %h want 039F250D", word_seg);
    end
    step(1);
    checks++;
    if (word_seg[31:24] !== 8'h63) begin
      errors++;
      $display("FAIL live_write got %h want 63", word_seg[31:24]);
    end
  endtask

  task automatic test_start_stop;
    start = 1'b1;
    stop = 1'b1;
    cfg_len = 5'd4;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || seg_valid !== 1'b0 || word_seg !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL start_stop got busy=%b valid=%b word=%h want 0 0 FFFFFFFF",
               busy, seg_valid, word_seg);
    end
    step(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_decode;
    wr(4'd0, "9");
    wr(4'd1, "-");
    wr(4'd2, "a");
    wr(4'd3, " ");
    go(5'd4);
    step(1);
    checks++;
    if (word_seg !== 32'h09FD_11FF) begin
      errors++;
      $display("FAIL decode got %h want 09FD11FF", word_seg);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_char = '0;
    start = 1'b0;
    stop = 1'b0;
    cfg_len = '0;
    test_reset;
    test_scroll;
    test_wrap;
    test_short_len;
    test_live_write;
    test_start_stop;
    test_decode;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
